wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Writeback arbiter and load scoreboard; it is the write-side master of the CPU register file. It merges single-cycle ALU results with variable-latency load responses onto the single register-file write port (rd/rd_data). Load responses are buffered in a small FIFO. A pending-load bitmap drives a combinational operand hazard flag back to decode.

## Interface

Parameters:
- DEPTH, 4: load-response FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  core clock; all state updates on posedge.
- nrst  in  1  asynchronous active-low reset.
- alu_rd  in  CPU_REGNO_WIDTH (5)  ALU destination register; 0 means no write this cycle.
- alu_data  in  CPU_REG_WIDTH (32)  ALU result.
- ld_issue  in  1  a load is issued this cycle.
- ld_issue_rd  in  5  destination register of the issued load.
- ld_valid  in  1  load response valid.
- ld_ready  out  1  load response accepted; equals FIFO not full.
- ld_rd  in  5  load response destination register.
- ld_data  in  32  load response data.
- rs  in  5  decode source operand 1.
- rt  in  5  decode source operand 2.
- hazard  out  1  rs or rt has a load outstanding.
- rd  out  5  register-file write index, registered; 0 means idle.
- rd_data  out  32  register-file write data, registered.

## Operation

- ALU slot has absolute priority and no backpressure. If alu_rd != 0, the next rd/rd_data = alu_rd/alu_data.
- Otherwise, if the FIFO is non-empty, pop the head into rd/rd_data.
- Otherwise, if a load response is accepted this cycle, it flows through directly to rd/rd_data and bypasses the FIFO.
- Otherwise rd = 0. rd_data holds its previous value.
- A load response is accepted when ld_valid && ld_ready. It is pushed into the FIFO unless it takes the flow-through path.
- ld_ready = (count < DEPTH). It is combinational from registered count only and never depends on ld_valid.
- The sender holds ld_rd/ld_data stable while ld_valid && !ld_ready.
- Push and pop in the same cycle: count is unchanged and the pointers both advance. This is legal when full, but ld_ready is still low when full, so no push happens at count == DEPTH.
- Load responses with ld_rd == 0 are accepted and dropped: no FIFO entry, no write.
- FIFO order is strict arrival order. Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is log2(DEPTH)+1 bits.
- Scoreboard pend[31:1]; pend[0] is constant 0.
  - Set: ld_issue && ld_issue_rd != 0 sets pend[ld_issue_rd].
  - Clear: a load result written to rd (FIFO pop or flow-through) with rd = r clears pend[r].
  - Same register set and cleared in one cycle: the set wins.
  - ALU writes never touch pend.
- WAW ordering (an ALU write to a register with a load pending) is prevented upstream by issue logic; this block does not check it.
- hazard = (rs != 0 && pend[rs]) || (rt != 0 && pend[rt]).

## Timing

- Reset values:
  - rd = 0, rd_data = 0, pend = 0.
  - FIFO pointers and count = 0.
  - ld_ready = 1, hazard = 0.
- Reset mid-operation discards all FIFO contents and pending bits immediately (asynchronous).
- ALU latency: alu_rd sampled at edge N appears on rd during cycle N+1.
- Load latency:
  - Flow-through: 1 cycle from acceptance.
  - Buffered: 1 cycle after the first cycle in which alu_rd == 0 and the entry is at the head.
- pend[r] clears at the same edge that loads the load result onto rd. hazard for r therefore deasserts in the cycle the value is presented on rd/rd_data. The register file's write bypass makes that value readable in that cycle.
- hazard is combinational from rs, rt and registered pend; it has zero latency.
- Sustained ALU traffic can starve the FIFO indefinitely. Backpressure to the load unit via ld_ready is the intended relief.

## Test plan

- Reset release, idle:
  - Stimulus: nrst low, then high, all inputs 0.
  - Response: rd = 0, rd_data = 0, ld_ready = 1, hazard = 0 on every cycle.
- ALU passthrough:
  - Stimulus: alu_rd = 5, alu_data = 0xDEADBEEF at edge N.
  - Response: rd = 5, rd_data = 0xDEADBEEF during cycle N+1; rd = 0 in N+2.
- Load flow-through with scoreboard:
  - Stimulus: ld_issue rd = 8; rs = 8 the next cycle; later ld_valid rd = 8, data 0x1234 with alu_rd = 0.
  - Response: hazard = 1 until the cycle rd = 8, rd_data = 0x1234 appears, then hazard = 0.
- Conflict and buffering:
  - Stimulus: ALU writes r1..r6 on 6 consecutive cycles; loads to r10..r15 offered back-to-back.
  - Response:
    - Loads r10..r13 accepted; ld_ready = 0 after the 4th.
    - Once ALU traffic stops, r10..r15 are written in order on consecutive cycles.
    - No write is lost or duplicated.
- Zero register and set/clear collision:
  - Stimulus: load response with ld_rd = 0 is dropped (rd stays 0). Then, in one cycle, a buffered load for r3 commits while ld_issue_rd = 3.
  - Response: pend[3] remains 1 and hazard for rs = 3 stays high.
- Async reset mid-operation:
  - Stimulus: FIFO holds 3 entries and pend has 3 bits set; assert nrst between clock edges.
  - Response: all outputs reach reset values immediately, and no buffered write appears after release.

Source files
------------

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU results and load responses onto the
// register-file write port, with a load-response FIFO and pending-load scoreboard.
module wb_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        ld_issue,
  input  logic [4:0]  ld_issue_rd,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [4:0]  ld_rd,
  input  logic [31:0] ld_data,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  output logic        hazard,
  output logic [4:0]  rd,
  output logic [31:0] rd_data
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] L_FULL = (AW+1)'(DEPTH);

  logic [AW:0]   r_count;
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [4:0]    r_mem_rd   [DEPTH];
  logic [31:0]   r_mem_data [DEPTH];
  logic [31:1]   r_pend;
  logic [4:0]    r_rd;
  logic [31:0]   r_rd_data;

  logic        w_alu;
  logic        w_empty;
  logic        w_accept;
  logic        w_ld_nz;
  logic        w_pop;
  logic        w_flow;
  logic        w_push;
  logic        w_ld_wr;
  logic [4:0]  w_ld_wr_rd;
  logic [31:0] w_ld_wr_data;
  logic [31:0] w_pend_full;
  logic [31:0] w_set;
  logic [31:0] w_clr;
  logic [31:0] w_pend_nxt;

  assign ld_ready = (r_count < L_FULL);
  assign w_alu    = (alu_rd != 5'd0);
  assign w_empty  = (r_count == '0);
  assign w_accept = ld_valid && ld_ready;
  assign w_ld_nz  = (ld_rd != 5'd0);

  // Flow-through only when nothing is queued, so arrival order holds.
  assign w_pop  = !w_alu && !w_empty;
  assign w_flow = !w_alu && w_empty && w_accept && w_ld_nz;
  assign w_push = w_accept && w_ld_nz && !w_flow;

  assign w_ld_wr      = w_pop || w_flow;
  assign w_ld_wr_rd   = w_pop ? r_mem_rd[r_rptr] : ld_rd;
  assign w_ld_wr_data = w_pop ? r_mem_data[r_rptr] : ld_data;

  assign w_pend_full = {r_pend, 1'b0};
  assign hazard = w_pend_full[rs] || w_pend_full[rt];

  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (ld_issue) w_set[ld_issue_rd] = 1'b1;
    if (w_ld_wr) w_clr[w_ld_wr_rd] = 1'b1;
    // Set after clear: a re-issued load keeps the register pending.
    w_pend_nxt = (w_pend_full & ~w_clr) | w_set;
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_rd[r_wptr]   <= ld_rd;
      r_mem_data[r_wptr] <= ld_data;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_count   <= '0;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_pend    <= '0;
      r_rd      <= '0;
      r_rd_data <= '0;
    end else begin
      r_pend <= w_pend_nxt[31:1];
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop) r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
      if (w_alu) begin
        r_rd      <= alu_rd;
        r_rd_data <= alu_data;
      end else if (w_ld_wr) begin
        r_rd      <= w_ld_wr_rd;
        r_rd_data <= w_ld_wr_data;
      end else begin
        r_rd <= '0;
      end
    end
  end

  assign rd      = r_rd;
  assign rd_data = r_rd_data;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed vector bench for wb_arbiter.
// Rows drive one cycle; comb outputs checked before the edge, rd after.
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        nrst;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_issue;
  logic [4:0]  ld_issue_rd;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic        hazard;
  logic [4:0]  rd;
  logic [31:0] rd_data;

  int checks = 0;
  int failures = 0;

  wb_arbiter #(.DEPTH(4)) dut (
    .clk         (clk),
    .nrst        (nrst),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .ld_issue    (ld_issue),
    .ld_issue_rd (ld_issue_rd),
    .ld_valid    (ld_valid),
    .ld_ready    (ld_ready),
    .ld_rd       (ld_rd),
    .ld_data     (ld_data),
    .rs          (rs),
    .rt          (rt),
    .hazard      (hazard),
    .rd          (rd),
    .rd_data     (rd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        iss;
    logic [4:0]  iss_rd;
    logic        v;
    logic [4:0]  lrd;
    logic [31:0] ldat;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        e_rdy;
    logic        e_haz;
    logic [4:0]  e_rd;
    logic [31:0] e_dat;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(
    input logic [4:0] a, input logic [31:0] ad,
    input logic i, input logic [4:0] ir,
    input logic v, input logic [4:0] lr, input logic [31:0] ld,
    input logic [4:0] s, input logic [4:0] t,
    input logic er, input logic eh,
    input logic [4:0] erd, input logic [31:0] ed);
    vec_t x;
    x.alu_rd = a; x.alu_data = ad;
    x.iss = i; x.iss_rd = ir;
    x.v = v; x.lrd = lr; x.ldat = ld;
    x.rs = s; x.rt = t;
    x.e_rdy = er; x.e_haz = eh;
    x.e_rd = erd; x.e_dat = ed;
    return x;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic drive_zero();
    alu_rd = 0; alu_data = 0;
    ld_issue = 0; ld_issue_rd = 0;
    ld_valid = 0; ld_rd = 0; ld_data = 0;
    rs = 0; rt = 0;
  endtask

  task automatic apply(input vec_t x, input int n);
    @(negedge clk);
    alu_rd = x.alu_rd; alu_data = x.alu_data;
    ld_issue = x.iss; ld_issue_rd = x.iss_rd;
    ld_valid = x.v; ld_rd = x.lrd; ld_data = x.ldat;
    rs = x.rs; rt = x.rt;
    #1;
    chk($sformatf("v%0d.ld_ready", n), 32'(ld_ready), 32'(x.e_rdy));
    chk($sformatf("v%0d.hazard", n), 32'(hazard), 32'(x.e_haz));
    @(posedge clk);
    #1;
    chk($sformatf("v%0d.rd", n), 32'(rd), 32'(x.e_rd));
    chk($sformatf("v%0d.rd_data", n), rd_data, x.e_dat);
  endtask

  initial begin
    nrst = 1'b0;
    drive_zero();
    // idle, ALU passthrough, load flow-through with scoreboard
    vq.push_back(mk(0,0, 0,0, 0,0,0, 0,0, 1,0, 0,0));
    vq.push_back(mk(5,32'hDEADBEEF, 0,0, 0,0,0, 0,0, 1,0, 5,32'hDEADBEEF));
    vq.push_back(mk(0,0, 0,0, 0,0,0, 0,0, 1,0, 0,32'hDEADBEEF));
    vq.push_back(mk(0,0, 1,8, 0,0,0, 8,0, 1,0, 0,32'hDEADBEEF));
    vq.push_back(mk(0,0, 0,0, 0,0,0, 8,0, 1,1, 0,32'hDEADBEEF));
    vq.push_back(mk(0,0, 0,0, 1,8,32'h1234, 8,0, 1,1, 8,32'h1234));
    vq.push_back(mk(0,0, 0,0, 0,0,0, 8,0, 1,0, 0,32'h1234));
    // zero-register load dropped
    vq.push_back(mk(0,0, 0,0, 1,0,32'h5555, 0,0, 1,0, 0,32'h1234));
    vq.push_back(mk(0,0, 0,0, 0,0,0, 0,0, 1,0, 0,32'h1234));
    // ALU r1..r6 vs loads r10..r15
    vq.push_back(mk(1,32'hA1, 0,0, 1,10,32'hBA, 0,0, 1,0, 1,32'hA1));
    vq.push_back(mk(2,32'hA2, 0,0, 1,11,32'hBB, 0,0, 1,0, 2,32'hA2));
    vq.push_back(mk(3,32'hA3, 0,0, 1,12,32'hBC, 0,0, 1,0, 3,32'hA3));
    vq.push_back(mk(4,32'hA4, 0,0, 1,13,32'hBD, 0,0, 1,0, 4,32'hA4));
    vq.push_back(mk(5,32'hA5, 0,0, 1,14,32'hBE, 0,0, 0,0, 5,32'hA5));
    vq.push_back(mk(6,32'hA6, 0,0, 1,14,32'hBE, 0,0, 0,0, 6,32'hA6));
    vq.push_back(mk(0,0, 0,0, 1,14,32'hBE, 0,0, 0,0, 10,32'hBA));
    vq.push_back(mk(0,0, 0,0, 1,14,32'hBE, 0,0, 1,0, 11,32'hBB));
    vq.push_back(mk(0,0, 0,0, 1,15,32'hBF, 0,0, 1,0, 12,32'hBC));
    vq.push_back(mk(0,0, 0,0, 0,0,0, 0,0, 1,0, 13,32'hBD));
    vq.push_back(mk(0,0, 0,0, 0,0,0, 0,0, 1,0, 14,32'hBE));
    vq.push_back(mk(0,0, 0,0, 0,0,0, 0,0, 1,0, 15,32'hBF));
    vq.push_back(mk(0,0, 0,0, 0,0,0, 0,0, 1,0, 0,32'hBF));
    // set/clear collision on r3
    vq.push_back(mk(0,0, 1,3, 0,0,0, 3,0, 1,0, 0,32'hBF));
    vq.push_back(mk(2,32'h22, 0,0, 1,3,32'h33, 3,0, 1,1, 2,32'h22));
    vq.push_back(mk(0,0, 1,3, 0,0,0, 3,0, 1,1, 3,32'h33));
    vq.push_back(mk(0,0, 0,0, 0,0,0, 0,3, 1,1, 0,32'h33));
    vq.push_back(mk(0,0, 0,0, 1,3,32'h44, 3,0, 1,1, 3,32'h44));
    vq.push_back(mk(0,0, 0,0, 0,0,0, 3,3, 1,0, 0,32'h44));

    #12;
    chk("rst.rd", 32'(rd), 32'd0);
    chk("rst.rd_data", rd_data, 32'd0);
    chk("rst.ld_ready", 32'(ld_ready), 32'd1);
    chk("rst.hazard", 32'(hazard), 32'd0);
    @(negedge clk);
    nrst = 1'b1;

    for (int i = 0; i < vq.size(); i++) apply(vq[i], i);

    // fill FIFO with 3 loads under ALU traffic, then reset mid-flight
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      alu_rd = 5'(k + 1);
      alu_data = 32'(k + 1);
      ld_issue = 1'b1; ld_issue_rd = 5'(20 + k);
      ld_valid = 1'b1; ld_rd = 5'(20 + k);
      ld_data = 32'h100 + 32'(k);
    end
    @(negedge clk);
    drive_zero();
    rs = 20; rt = 21;
    #1;
    chk("pre.rd", 32'(rd), 32'd3);
    chk("pre.hazard", 32'(hazard), 32'd1);
    #1;
    nrst = 1'b0;
    #1;
    chk("arst.rd", 32'(rd), 32'd0);
    chk("arst.rd_data", rd_data, 32'd0);
    chk("arst.ld_ready", 32'(ld_ready), 32'd1);
    chk("arst.hazard", 32'(hazard), 32'd0);
    @(posedge clk);
    @(negedge clk);
    nrst = 1'b1;
    rs = 22; rt = 20;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("post%0d.rd", k), 32'(rd), 32'd0);
      chk($sformatf("post%0d.hazard", k), 32'(hazard), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
